// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - light codes, phase enum and light decode helpers
package tl_pkg;
  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  typedef enum logic [2:0] {A_GRN, A_YEL, B_GRN, B_YEL, ALL_RED, WALK} tl_state_t;

  function automatic logic [1:0] light_a(input tl_state_t s);
    case (s)
      A_GRN:   light_a = GREEN;
      A_YEL:   light_a = YELLOW;
      default: light_a = RED;
    endcase
  endfunction

  function automatic logic [1:0] light_b(input tl_state_t s);
    case (s)
      B_GRN:   light_b = GREEN;
      B_YEL:   light_b = YELLOW;
      default: light_b = RED;
    endcase
  endfunction
endpackage

// File: rtl/tl_phase_timer.sv
// rtl/tl_phase_timer.sv - phase counter: clear on entry, count up, hold at limit
module tl_phase_timer import tl_pkg::*; #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (r_cnt < i_limit)
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/tl_phase_scheduler.sv
// rtl/tl_phase_scheduler.sv - intersection phase FSM with ped latch, parade mode and Moore light registers
module tl_phase_scheduler import tl_pkg::*; #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 8,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 3,
  parameter int CNT_W     = 8
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_car_a,
  input  logic       i_car_b,
  input  logic       i_ped_req,
  input  logic       i_P,
  input  logic       i_R,
  output logic [1:0] o_LA,
  output logic [1:0] o_LB,
  output logic       o_walk,
  output logic       o_ped_ack,
  output logic       o_mode
);
  localparam logic [CNT_W-1:0] L_MIN  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] L_YEL  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] L_RED  = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] L_WALK = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] L_FULL = '1;

  tl_state_t        r_state, w_next;
  logic             r_next_b, w_next_b;
  logic             r_ped, r_mode;
  logic [CNT_W-1:0] w_t, w_limit;
  logic             w_exit, w_min_ok, w_at_max, w_ped_go, w_enter_walk;

  assign w_min_ok     = (w_t >= L_MIN);
  assign w_at_max     = (w_t == L_MAX);
  assign w_ped_go     = r_ped && !r_mode;
  assign w_limit      = (r_state == A_GRN || r_state == B_GRN) ? L_MAX : L_FULL;
  assign w_exit       = (w_next != r_state);
  assign w_enter_walk = w_exit && (w_next == WALK);

  tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_clr   (w_exit),
    .i_limit (w_limit),
    .o_cnt   (w_t)
  );

  always_comb begin
    w_next   = r_state;
    w_next_b = r_next_b;
    case (r_state)
      A_GRN: if (w_min_ok && (w_ped_go || (i_car_b && !i_car_a) || (i_car_b && w_at_max) || r_mode))
               w_next = A_YEL;
      // parade mode pins B green regardless of demand
      B_GRN: if (!r_mode && w_min_ok && (w_ped_go || (i_car_a && !i_car_b) || (i_car_a && w_at_max)))
               w_next = B_YEL;
      A_YEL: if (w_t == L_YEL) begin
               w_next   = ALL_RED;
               w_next_b = 1'b1;
             end
      B_YEL: if (w_t == L_YEL) begin
               w_next   = ALL_RED;
               w_next_b = 1'b0;
             end
      ALL_RED: if (w_t == L_RED)
                 w_next = w_ped_go ? WALK : (r_next_b ? B_GRN : A_GRN);
      WALK:  if (w_t == L_WALK) w_next = ALL_RED;
      default: w_next = A_GRN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= A_GRN;
      r_next_b  <= 1'b1;
      r_ped     <= 1'b0;
      r_mode    <= 1'b0;
      o_LA      <= GREEN;
      o_LB      <= RED;
      o_walk    <= 1'b0;
      o_ped_ack <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_next_b  <= w_next_b;
      // a press on the walk-entry edge is kept for the next all-red
      r_ped     <= (r_ped && !w_enter_walk) || i_ped_req;
      r_mode    <= !i_R && (r_mode || i_P);
      o_LA      <= light_a(w_next);
      o_LB      <= light_b(w_next);
      o_walk    <= (w_next == WALK);
      o_ped_ack <= w_enter_walk;
    end
  end

  assign o_mode = r_mode;
endmodule

// File: tb/tb_tl_phase_scheduler.sv
// tb/tb_tl_phase_scheduler.sv - directed scenarios checked against a phase/duration model
module tb_tl_phase_scheduler;
  localparam int MIN_GREEN = 4;
  localparam int MAX_GREEN = 8;
  localparam int YELLOW_T  = 2;
  localparam int ALLRED_T  = 1;
  localparam int WALK_T    = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic car_a = 1'b0, car_b = 1'b0, ped = 1'b0, p = 1'b0, r = 1'b0;
  logic [1:0] la, lb;
  logic walk, ack, mode;
  int checks = 0;
  int errors = 0;
  int ecnt = 0;

  always #5 clk = ~clk;

  tl_phase_scheduler dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_car_a   (car_a),
    .i_car_b   (car_b),
    .i_ped_req (ped),
    .i_P       (p),
    .i_R       (r),
    .o_LA      (la),
    .o_LB      (lb),
    .o_walk    (walk),
    .o_ped_ack (ack),
    .o_mode    (mode)
  );

  // phases: 0 A green, 1 A yellow, 2 B green, 3 B yellow, 4 all red, 5 walk
  int dur[6]    = '{0, YELLOW_T, 0, YELLOW_T, ALLRED_T, WALK_T};
  int la_tab[6] = '{0, 1, 2, 2, 2, 2};
  int lb_tab[6] = '{2, 2, 0, 1, 2, 2};
  int m_ph, m_el;
  bit m_nx, m_ped, m_mode, m_ack;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, ecnt, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_nx = 1; m_ped = 0; m_mode = 0; m_ack = 0;
  endtask

  task automatic model_edge();
    int np;
    int served;
    bit nx;
    bit ped_go;
    np = m_ph; served = m_el + 1; nx = m_nx; ped_go = m_ped && !m_mode;
    case (m_ph)
      0: if (served >= MIN_GREEN && (ped_go || (car_b && !car_a) ||
             (car_b && served >= MAX_GREEN) || m_mode)) np = 1;
      2: if (!m_mode && served >= MIN_GREEN && (ped_go || (car_a && !car_b) ||
             (car_a && served >= MAX_GREEN))) np = 3;
      default:
        if (served == dur[m_ph]) begin
          case (m_ph)
            1: begin np = 4; nx = 1; end
            3: begin np = 4; nx = 0; end
            4: np = ped_go ? 5 : (m_nx ? 2 : 0);
            default: np = 4;
          endcase
        end
    endcase
    m_ack = (np == 5) && (m_ph != 5);
    if (m_ack) m_ped = 0;
    if (ped) m_ped = 1;
    if (r) m_mode = 0;
    else if (p) m_mode = 1;
    m_el = (np == m_ph) ? m_el + 1 : 0;
    m_ph = np;
    m_nx = nx;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    ecnt++;
    #1;
    check("LA", la, la_tab[m_ph]);
    check("LB", lb, lb_tab[m_ph]);
    check("walk", walk, (m_ph == 5) ? 1 : 0);
    check("ped_ack", ack, m_ack ? 1 : 0);
    check("mode", mode, m_mode ? 1 : 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    car_a = 0; car_b = 0; ped = 0; p = 0; r = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_LA", la, 0);
    check("rst_LB", lb, 2);
    check("rst_walk", walk, 0);
    check("rst_ack", ack, 0);
    check("rst_mode", mode, 0);
    rstn = 1'b1;
    ecnt = 0;
  endtask

  initial begin
    int e_clr, yel_e, walk_e, ag_e, walk_cnt;

    // 1: A demand only, A holds
    do_reset();
    car_a = 1;
    repeat (20) step();
    check("s1_LA_hold", la, 0);

    // 2: B demand from reset
    do_reset();
    car_b = 1;
    repeat (8) begin
      step();
      if (ecnt == 3) check("s2_LA_e3", la, 0);
      if (ecnt == 4) check("s2_LA_e4", la, 1);
      if (ecnt == 6) check("s2_LB_e6", lb, 2);
      if (ecnt == 7) check("s2_LB_e7", lb, 0);
    end

    // 3: both streets loaded, max-green alternation
    do_reset();
    car_a = 1; car_b = 1;
    repeat (40) begin
      step();
      if (ecnt == 7)  check("s3_LA_e7", la, 0);
      if (ecnt == 8)  check("s3_LA_e8", la, 1);
      if (ecnt == 11) check("s3_LB_e11", lb, 0);
      if (ecnt == 19) check("s3_LB_e19", lb, 1);
      if (ecnt == 22) check("s3_LA_e22", la, 0);
    end

    // 4: single ped press, no cars
    do_reset();
    repeat (16) begin
      ped = (ecnt == 4);
      step();
      if (ecnt == 6)  check("s4_LA_e6", la, 1);
      if (ecnt == 8)  check("s4_LA_e8", la, 2);
      if (ecnt == 9)  check("s4_ack_e9", ack, 1);
      if (ecnt == 11) check("s4_walk_e11", walk, 1);
      if (ecnt == 12) check("s4_walk_e12", walk, 0);
      if (ecnt == 13) check("s4_LB_e13", lb, 0);
    end
    ped = 0;

    // 5: parade holds B, ped deferred, P+R clears, then walk then A
    do_reset();
    p = 1;
    step();
    p = 0; car_a = 1;
    repeat (6) step();
    check("s5_LB_e7", lb, 0);
    walk_cnt = 0;
    repeat (30) begin
      ped = (ecnt == 15);
      step();
      if (walk) walk_cnt++;
    end
    ped = 0;
    check("s5_LB_held", lb, 0);
    check("s5_no_walk", walk_cnt, 0);
    p = 1; r = 1;
    step();
    p = 0; r = 0;
    check("s5_mode_clr", mode, 0);
    e_clr = ecnt; yel_e = -1; walk_e = -1; ag_e = -1;
    repeat (20) begin
      step();
      if (yel_e < 0 && lb == 2'b01) yel_e = ecnt;
      if (walk_e < 0 && walk) walk_e = ecnt;
      if (walk_e > 0 && ag_e < 0 && la == 2'b00) ag_e = ecnt;
    end
    check("s5_yield_lat", yel_e - e_clr, 1);
    check("s5_walk_lat", walk_e - e_clr, 4);
    check("s5_A_lat", ag_e - e_clr, 8);

    // 6: asynchronous reset during B yellow
    do_reset();
    car_b = 1;
    repeat (7) step();
    car_b = 0; car_a = 1;
    repeat (3) step();
    ped = 1; p = 1;
    step();
    ped = 0; p = 0;
    check("s6_LB_yel", lb, 1);
    check("s6_mode_set", mode, 1);
    rstn = 1'b0;
    #2;
    check("s6_async_LA", la, 0);
    check("s6_async_LB", lb, 2);
    check("s6_async_mode", mode, 0);
    check("s6_async_walk", walk, 0);
    model_reset();
    car_a = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    ecnt = 0;
    repeat (10) begin
      step();
      if (ecnt == 6) check("s6_ped_cleared", la, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
